// File: rtl/cnn_layer_accel_layer_eng_arbiter.sv
// Round-robin arbiter sharing one layer-engine packet port between requesters,
// with a watchdog that substitutes a timeout completion for a hung engine.
module cnn_layer_accel_layer_eng_arbiter #(
  parameter int C_PACKET_WIDTH   = 66,
  parameter int C_NUM_REQUESTERS = 4,
  parameter int C_TIMEOUT_WIDTH  = 16,
  parameter int C_TIMEOUT_CYCLES = 4096
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [C_NUM_REQUESTERS-1:0]                  req_valid,
  output logic [C_NUM_REQUESTERS-1:0]                  req_accept,
  input  logic [C_NUM_REQUESTERS*C_PACKET_WIDTH-1:0]   req_data,
  output logic                                         eng_input_valid,
  input  logic                                         eng_input_accept,
  output logic [C_PACKET_WIDTH-1:0]                    eng_input_data,
  input  logic                                         eng_output_valid,
  output logic                                         eng_output_accept,
  input  logic [C_PACKET_WIDTH-1:0]                    eng_output_data,
  output logic [C_NUM_REQUESTERS-1:0]                  rsp_valid,
  input  logic [C_NUM_REQUESTERS-1:0]                  rsp_accept,
  output logic [C_PACKET_WIDTH-1:0]                    rsp_data,
  output logic                                         rsp_timeout,
  output logic                                         busy,
  output logic [((C_NUM_REQUESTERS > 1) ? $clog2(C_NUM_REQUESTERS) : 1)-1:0] grant_idx
);

  localparam int IDXW = (C_NUM_REQUESTERS > 1) ? $clog2(C_NUM_REQUESTERS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(C_NUM_REQUESTERS - 1);
  localparam logic [C_TIMEOUT_WIDTH-1:0] TMO_LAST = C_TIMEOUT_WIDTH'(C_TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE            = 2'd0;
  localparam logic [1:0] ST_FORWARD         = 2'd1;
  localparam logic [1:0] ST_WAIT_COMPLETION = 2'd2;
  localparam logic [1:0] ST_RETURN          = 2'd3;

  logic [1:0]                 state_q, state_d;
  logic [IDXW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0]            grant_q, grant_d;
  logic [C_TIMEOUT_WIDTH-1:0] timer_q, timer_d;
  logic [C_PACKET_WIDTH-1:0]  pkt_q, pkt_d;
  logic [C_PACKET_WIDTH-1:0]  rsp_q, rsp_d;
  logic                       tmo_q, tmo_d;

  logic [IDXW-1:0] win_lo, win_hi, win;
  logic            found_lo, found_hi, found;

  // Lowest valid index at/after rr_ptr wins; otherwise wrap to the lowest valid index.
  always_comb begin
    win_lo   = '0;
    win_hi   = '0;
    found_lo = 1'b0;
    found_hi = 1'b0;
    for (int unsigned i = C_NUM_REQUESTERS; i > 0; i--) begin
      if (req_valid[i-1]) begin
        win_lo   = IDXW'(i - 1);
        found_lo = 1'b1;
        if ((i - 1) >= 32'(rr_ptr_q)) begin
          win_hi   = IDXW'(i - 1);
          found_hi = 1'b1;
        end
      end
    end
    found = found_lo;
    win   = found_hi ? win_hi : win_lo;
  end

  always_comb begin
    state_d           = state_q;
    rr_ptr_d          = rr_ptr_q;
    grant_d           = grant_q;
    timer_d           = timer_q;
    pkt_d             = pkt_q;
    rsp_d             = rsp_q;
    tmo_d             = tmo_q;
    req_accept        = '0;
    eng_input_valid   = 1'b0;
    eng_output_accept = 1'b0;
    rsp_valid         = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (found && !rst) begin
          req_accept[win] = 1'b1;
          pkt_d           = req_data[win*C_PACKET_WIDTH +: C_PACKET_WIDTH];
          grant_d         = win;
          state_d         = ST_FORWARD;
        end
      end
      ST_FORWARD: begin
        eng_input_valid = 1'b1;
        if (eng_input_accept) begin
          timer_d = '0;
          state_d = ST_WAIT_COMPLETION;
        end
      end
      ST_WAIT_COMPLETION: begin
        eng_output_accept = 1'b1;
        timer_d = (timer_q == '1) ? timer_q : timer_q + C_TIMEOUT_WIDTH'(1);
        // A real completion takes priority over a watchdog expiry on the same cycle.
        if (eng_output_valid) begin
          rsp_d   = eng_output_data;
          tmo_d   = 1'b0;
          state_d = ST_RETURN;
        end else if (C_TIMEOUT_CYCLES != 0 && timer_q == TMO_LAST) begin
          rsp_d   = '1;
          tmo_d   = 1'b1;
          state_d = ST_RETURN;
        end
      end
      ST_RETURN: begin
        rsp_valid[grant_q] = 1'b1;
        if (rsp_accept[grant_q]) begin
          rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + IDXW'(1);
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      timer_q  <= '0;
      pkt_q    <= '0;
      rsp_q    <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      timer_q  <= timer_d;
      pkt_q    <= pkt_d;
      rsp_q    <= rsp_d;
      tmo_q    <= tmo_d;
    end
  end

  assign eng_input_data = pkt_q;
  assign rsp_data       = rsp_q;
  assign rsp_timeout    = tmo_q;
  assign busy           = (state_q != ST_IDLE);
  assign grant_idx      = grant_q;

endmodule

// File: tb/tb_cnn_layer_accel_layer_eng_arbiter.sv
// Directed bench: one arbiter with an 8-cycle watchdog, one with the watchdog disabled.
module tb_cnn_layer_accel_layer_eng_arbiter;

  localparam int W = 66;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   req_valid, req_accept;
  logic [N*W-1:0] req_data;
  logic           eng_input_valid, eng_input_accept;
  logic [W-1:0]   eng_input_data;
  logic           eng_output_valid, eng_output_accept;
  logic [W-1:0]   eng_output_data;
  logic [N-1:0]   rsp_valid, rsp_accept;
  logic [W-1:0]   rsp_data;
  logic           rsp_timeout, busy;
  logic [1:0]     grant_idx;

  logic [N-1:0]   b_req_valid, b_req_accept, b_rsp_valid, b_rsp_accept;
  logic           b_eng_input_valid, b_eng_input_accept;
  logic [W-1:0]   b_eng_input_data, b_rsp_data;
  logic           b_eng_output_accept, b_rsp_timeout, b_busy;
  logic [1:0]     b_grant_idx;

  cnn_layer_accel_layer_eng_arbiter #(
    .C_PACKET_WIDTH(W), .C_NUM_REQUESTERS(N), .C_TIMEOUT_WIDTH(16), .C_TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_accept(req_accept), .req_data(req_data),
    .eng_input_valid(eng_input_valid), .eng_input_accept(eng_input_accept),
    .eng_input_data(eng_input_data),
    .eng_output_valid(eng_output_valid), .eng_output_accept(eng_output_accept),
    .eng_output_data(eng_output_data),
    .rsp_valid(rsp_valid), .rsp_accept(rsp_accept), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .busy(busy), .grant_idx(grant_idx)
  );

  cnn_layer_accel_layer_eng_arbiter #(
    .C_PACKET_WIDTH(W), .C_NUM_REQUESTERS(N), .C_TIMEOUT_WIDTH(16), .C_TIMEOUT_CYCLES(0)
  ) dut_nowd (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_accept(b_req_accept), .req_data(req_data),
    .eng_input_valid(b_eng_input_valid), .eng_input_accept(b_eng_input_accept),
    .eng_input_data(b_eng_input_data),
    .eng_output_valid(1'b0), .eng_output_accept(b_eng_output_accept),
    .eng_output_data(eng_output_data),
    .rsp_valid(b_rsp_valid), .rsp_accept(b_rsp_accept), .rsp_data(b_rsp_data),
    .rsp_timeout(b_rsp_timeout), .busy(b_busy), .grant_idx(b_grant_idx)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int fwd_cnt  = 0;
  int rsp_cnt  = 0;

  always @(posedge clk) begin
    if (eng_input_valid && eng_input_accept) fwd_cnt <= fwd_cnt + 1;
    if ((rsp_valid & rsp_accept) != '0)      rsp_cnt <= rsp_cnt + 1;
  end

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] slot_pkt(input int i);
    return W'(66'h0_A000) + W'(i);
  endfunction

  initial begin
    logic [W-1:0] held;
    int fwd0, rsp0, b_seen;

    rst = 1'b1; req_valid = '1; req_data = '0; eng_input_accept = 1'b0;
    eng_output_valid = 1'b0; eng_output_data = '0; rsp_accept = '0;
    b_req_valid = '0; b_eng_input_accept = 1'b0; b_rsp_accept = '0;
    tick(); tick();

    // Reset state
    check("rst_req_accept", req_accept, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_idx, 0);
    check("rst_eng_valid", eng_input_valid, 0);
    check("rst_eng_data", eng_input_data, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_out_accept", eng_output_accept, 0);
    req_valid = '0; rst = 1'b0;
    tick();

    // Single job from requester 2
    for (int i = 0; i < N; i++) req_data[i*W +: W] = slot_pkt(i);
    req_data[2*W +: W] = 66'h1_2345;
    req_valid = 4'b0100;
    #1 check("single_req_accept", req_accept, 4'b0100);
    tick();
    req_valid = '0;
    check("single_eng_valid", eng_input_valid, 1);
    check("single_eng_data", eng_input_data, 66'h1_2345);
    check("single_grant", grant_idx, 2);
    check("single_busy", busy, 1);
    check("single_fwd_no_out_accept", eng_output_accept, 0);
    eng_input_accept = 1'b1; eng_output_valid = 1'b1; eng_output_data = 66'h3_0001;
    tick();
    eng_input_accept = 1'b0;
    check("single_wait_out_accept", eng_output_accept, 1);
    tick();
    eng_output_valid = 1'b0;
    check("single_rsp_valid", rsp_valid, 4'b0100);
    check("single_rsp_data", rsp_data, 66'h3_0001);
    check("single_rsp_timeout", rsp_timeout, 0);
    rsp_accept = 4'b1011;
    tick();
    check("single_ignore_other_accept", rsp_valid, 4'b0100);
    rsp_accept = 4'b0100;
    tick();
    rsp_accept = '0;
    check("single_busy_after", busy, 0);
    check("single_rsp_valid_after", rsp_valid, 0);

    // Fairness from a fresh pointer with an instant engine
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = slot_pkt(i);
    req_valid = '1; eng_input_accept = 1'b1; eng_output_valid = 1'b1; rsp_accept = '1;
    #1;
    for (int j = 0; j < 6; j++) begin
      int e;
      e = j % N;
      check("fair_idle_busy", busy, 0);
      check("fair_req_accept", req_accept, 4'(1) << e);
      tick();
      check("fair_grant", grant_idx, e);
      check("fair_eng_data", eng_input_data, slot_pkt(e));
      tick(); tick();
      check("fair_rsp_valid", rsp_valid, 4'(1) << e);
      tick();
    end
    req_valid = '0; eng_input_accept = 1'b0; eng_output_valid = 1'b0; rsp_accept = '0;
    tick();

    // Backpressure: pointer is at 2, only requester 0 asks
    fwd0 = fwd_cnt; rsp0 = rsp_cnt;
    req_data[0*W +: W] = 66'h2_AAAA_5555;
    req_valid = 4'b0001;
    #1 check("bp_req_accept", req_accept, 4'b0001);
    tick();
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      check("bp_eng_valid", eng_input_valid, 1);
      check("bp_eng_data", eng_input_data, 66'h2_AAAA_5555);
      tick();
    end
    eng_input_accept = 1'b1;
    tick();
    eng_input_accept = 1'b0;
    eng_output_valid = 1'b1; eng_output_data = 66'h0_DEAD;
    tick();
    eng_output_valid = 1'b0; eng_output_data = '0;
    for (int k = 0; k < 3; k++) begin
      check("bp_rsp_valid", rsp_valid, 4'b0001);
      check("bp_rsp_data", rsp_data, 66'h0_DEAD);
      tick();
    end
    rsp_accept = 4'b0001;
    tick();
    rsp_accept = '0;
    check("bp_one_forward", fwd_cnt - fwd0, 1);
    check("bp_one_response", rsp_cnt - rsp0, 1);
    check("bp_idle", busy, 0);

    // Watchdog expiry: requester 1, engine never completes
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    eng_input_accept = 1'b1;
    tick();
    eng_input_accept = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("tmo_no_rsp_yet", rsp_valid, 0);
      tick();
    end
    check("tmo_rsp_valid", rsp_valid, 4'b0010);
    held = '1;
    check("tmo_rsp_data", rsp_data, held);
    check("tmo_flag", rsp_timeout, 1);
    rsp_accept = 4'b0010;
    tick();
    rsp_accept = '0;

    // Completion on the same cycle the watchdog would fire: requester 2
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    eng_input_accept = 1'b1;
    tick();
    eng_input_accept = 1'b0;
    repeat (7) tick();
    check("race_no_rsp_yet", rsp_valid, 0);
    eng_output_valid = 1'b1; eng_output_data = 66'h1_5A5A;
    tick();
    eng_output_valid = 1'b0;
    check("race_rsp_valid", rsp_valid, 4'b0100);
    check("race_rsp_data", rsp_data, 66'h1_5A5A);
    check("race_flag", rsp_timeout, 0);
    rsp_accept = 4'b0100;
    tick();
    rsp_accept = '0;

    // Reset while holding a response for requester 1
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    eng_input_accept = 1'b1;
    tick();
    eng_input_accept = 1'b0;
    eng_output_valid = 1'b1; eng_output_data = 66'h0_BEEF;
    tick();
    eng_output_valid = 1'b0;
    check("mid_rsp_valid", rsp_valid, 4'b0010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rsp_valid_cleared", rsp_valid, 0);
    check("mid_busy", busy, 0);
    check("mid_grant", grant_idx, 0);
    check("mid_eng_valid", eng_input_valid, 0);
    req_data[3*W +: W] = 66'h3_3333;
    req_valid = 4'b1000;
    #1 check("mid_req3_accept", req_accept, 4'b1000);
    tick();
    req_valid = '0;
    check("mid_req3_grant", grant_idx, 3);
    check("mid_req3_data", eng_input_data, 66'h3_3333);
    rst = 1'b1; tick(); rst = 1'b0;

    // Watchdog disabled: a hung engine never produces a response
    b_req_valid = 4'b0001; b_eng_input_accept = 1'b1; b_rsp_accept = '1;
    tick();
    b_req_valid = '0;
    tick();
    b_eng_input_accept = 1'b0;
    b_seen = 0;
    for (int k = 0; k < 10000; k++) begin
      if (b_rsp_valid != '0) b_seen++;
      tick();
    end
    check("nowd_no_rsp", b_seen, 0);
    check("nowd_busy", b_busy, 1);
    check("nowd_out_accept", b_eng_output_accept, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
